// File: rtl/fsqrt_issue_if.sv
// rtl/fsqrt_issue_if.sv - request/result handshake bundle for fsqrt_issue
interface fsqrt_issue_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_nv;
  logic             busy;

  modport master (
    output in_valid, in_x, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag, out_nv, busy
  );

  modport slave (
    input  in_valid, in_x, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag, out_nv, busy
  );
endinterface

// File: rtl/fsqrt_issue.sv
// rtl/fsqrt_issue.sv - credit-controlled issue/collect wrapper around a 2-stage fsqrt; FSQRT_SPECIAL_EN adds IEEE special-case overrides

// Two-stage single-precision square root for positive normal operands.
// No reset: output is only trusted when the wrapper's shadow valid says so.
module fsqrt (
  input  logic        clk,
  input  logic [31:0] x,
  output logic [31:0] y
);
  logic [47:0] rad_d, rad_q;
  logic [7:0]  exp_d, exp_q;
  logic [8:0]  exp_sum;
  logic [26:0] rem;
  logic [26:0] trial;
  logic [23:0] root;
  logic        sqrt_unused;

  // Unbiased exponent halved; an odd unbiased exponent folds one factor of 2 into the radicand
  always_comb begin
    exp_sum = {1'b0, x[30:23]} + 9'd127;
    exp_d   = exp_sum[8:1];
    if (x[23] == 1'b0) begin
      rad_d = {1'b1, x[22:0], 24'b0};
    end else begin
      rad_d = {1'b0, 1'b1, x[22:0], 23'b0};
    end
  end

  // Stage 1: latch the prepared radicand and result exponent
  always_ff @(posedge clk) begin
    rad_q <= rad_d;
    exp_q <= exp_d;
  end

  // Restoring integer square root, one root bit per radicand bit pair (truncating)
  always_comb begin
    rem   = '0;
    root  = '0;
    trial = '0;
    for (int i = 23; i >= 0; i--) begin
      rem   = {rem[24:0], rad_q[2*i +: 2]};
      trial = {1'b0, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[22:0], 1'b1};
      end else begin
        root = {root[22:0], 1'b0};
      end
    end
  end

  // Stage 2: pack the result; the leading root bit is the implicit one
  always_ff @(posedge clk) begin
    y <= {1'b0, exp_q, root[22:0]};
  end

  assign sqrt_unused = ^{rem, root[23], x[31]};
endmodule

module fsqrt_issue #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rstn,
  fsqrt_issue_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] DEPTH_O = (AW+2)'(DEPTH);

  logic [31:0]      core_y;
  logic             accept;
  logic             pop;
  logic             v1, v2;
  logic [TAG_W-1:0] tag1, tag2;
  logic [31:0]      wr_y;
  logic             wr_nv;

  logic [31:0]      mem_y   [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic [AW+1:0]    occ;

  fsqrt u_core (
    .clk (clk),
    .x   (io.in_x),
    .y   (core_y)
  );

  // Credit covers buffered entries plus everything still inside the pipe, so a
  // write can never find the FIFO full; registered state only, no out_ready path
  assign occ         = {1'b0, count} + (AW+2)'(v1) + (AW+2)'(v2);
  assign io.in_ready = occ < DEPTH_O;
  assign accept      = io.in_valid & io.in_ready;
  assign io.out_valid = count != '0;
  assign pop         = io.out_valid & io.out_ready;
  assign io.busy     = v1 | v2 | (count != '0);

  // Valid/tag shadow of the non-stallable core pipeline
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      v1   <= accept;
      v2   <= v1;
      tag1 <= io.in_tag;
      tag2 <= tag1;
    end
  end

`ifdef FSQRT_SPECIAL_EN
  logic        spc_en_d, spc_nv_d;
  logic [31:0] spc_y_d;
  logic        spc1_en, spc1_nv, spc2_en, spc2_nv;
  logic [31:0] spc1_y, spc2_y;
  logic [31:0] mem_nv_y_unused;
  logic        mem_nv [DEPTH];

  // Classify the operand at issue; the core result is only used for positive normals
  always_comb begin
    spc_en_d = 1'b0;
    spc_nv_d = 1'b0;
    spc_y_d  = 32'h0;
    if (io.in_x[30:23] == 8'hFF && io.in_x[22:0] != 23'h0) begin
      spc_en_d = 1'b1;
      spc_y_d  = io.in_x | 32'h0040_0000;
      spc_nv_d = ~io.in_x[22];
    end else if (io.in_x[30:23] == 8'hFF) begin
      spc_en_d = 1'b1;
      spc_y_d  = io.in_x[31] ? 32'h7FC0_0000 : 32'h7F80_0000;
      spc_nv_d = io.in_x[31];
    end else if (io.in_x[30:23] == 8'h00) begin
      spc_en_d = 1'b1;
      spc_y_d  = {io.in_x[31], 31'b0};
    end else if (io.in_x[31]) begin
      spc_en_d = 1'b1;
      spc_y_d  = 32'h7FC0_0000;
      spc_nv_d = 1'b1;
    end
  end

  // Override travels alongside the shadow valid/tag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spc1_en <= 1'b0;
      spc1_nv <= 1'b0;
      spc1_y  <= '0;
      spc2_en <= 1'b0;
      spc2_nv <= 1'b0;
      spc2_y  <= '0;
    end else begin
      spc1_en <= spc_en_d;
      spc1_nv <= spc_nv_d;
      spc1_y  <= spc_y_d;
      spc2_en <= spc1_en;
      spc2_nv <= spc1_nv;
      spc2_y  <= spc1_y;
    end
  end

  assign wr_y  = spc2_en ? spc2_y : core_y;
  assign wr_nv = spc2_en & spc2_nv;
  assign mem_nv_y_unused = '0;

  // Flag storage for buffered results
  always_ff @(posedge clk) begin
    if (v2) begin
      mem_nv[wptr] <= wr_nv;
    end
  end

  assign io.out_nv = io.out_valid ? mem_nv[rptr] : 1'b0;
`else
  assign wr_y      = core_y;
  assign wr_nv     = 1'b0;
  assign io.out_nv = wr_nv;
`endif

  // Result storage; written when the shadow stage-2 valid marks core_y as live
  always_ff @(posedge clk) begin
    if (v2) begin
      mem_y[wptr]   <= wr_y;
      mem_tag[wptr] <= tag2;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      assert (!(v2 && count == DEPTH_C));
      if (v2) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({v2, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign io.out_y   = io.out_valid ? mem_y[rptr] : 32'h0;
  assign io.out_tag = io.out_valid ? mem_tag[rptr] : '0;
endmodule

// File: tb/tb_fsqrt_issue.sv
// tb/tb_fsqrt_issue.sv - directed and randomized checks for fsqrt_issue
module tb_fsqrt_issue;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  fsqrt_issue_if #(.TAG_W(5)) io ();

  fsqrt_issue #(.TAG_W(5), .DEPTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (io.slave)
  );

  // perfect squares and their roots: 1,4,16,64,9 -> 1,2,4,8,3
  logic [31:0] sq_x [5] = '{32'h3F800000, 32'h40800000, 32'h41800000, 32'h42800000, 32'h41100000};
  logic [31:0] sq_y [5] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000, 32'h40400000};
  logic [31:0] b_x  [3] = '{32'h3F800000, 32'h40800000, 32'h40000000};
  logic [4:0]  b_t  [3] = '{5'd1, 5'd2, 5'd4};

  logic [36:0] q [$];
  logic [36:0] exp_e;
  logic        rdy;
  int          acc, pushed, popped, cyc, seen, idx;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_in_ready"}, io.in_ready, 1);
    check({pfx, "_out_valid"}, io.out_valid, 0);
    check({pfx, "_out_y"}, io.out_y, 0);
    check({pfx, "_out_tag"}, io.out_tag, 0);
    check({pfx, "_out_nv"}, io.out_nv, 0);
    check({pfx, "_busy"}, io.busy, 0);
  endtask

  task automatic run_one(input logic [31:0] x, input logic [4:0] tag,
                         input logic [31:0] ey, input logic env, input string name);
    @(negedge clk);
    io.in_valid = 1'b1; io.in_x = x; io.in_tag = tag; io.out_ready = 1'b1;
    check({name, "_in_ready"}, io.in_ready, 1);
    @(negedge clk);
    io.in_valid = 1'b0;
    check({name, "_t1_valid"}, io.out_valid, 0);
    check({name, "_t1_busy"}, io.busy, 1);
    @(negedge clk);
    check({name, "_t2_valid"}, io.out_valid, 0);
    @(negedge clk);
    check({name, "_t3_valid"}, io.out_valid, 1);
    check({name, "_y"}, io.out_y, ey);
    check({name, "_tag"}, io.out_tag, tag);
    check({name, "_nv"}, io.out_nv, env);
    @(negedge clk);
    check({name, "_after_valid"}, io.out_valid, 0);
    check({name, "_after_busy"}, io.busy, 0);
  endtask

  initial begin
    io.in_valid = 1'b0; io.in_x = '0; io.in_tag = '0; io.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;

    run_one(32'h40800000, 5'd3, 32'h40000000, 1'b0, "single4");

    // back-to-back issue with consumer always ready
    @(negedge clk);
    io.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        check("b2b_in_ready", io.in_ready, 1);
        io.in_valid = 1'b1; io.in_x = b_x[k]; io.in_tag = b_t[k];
      end else begin
        io.in_valid = 1'b0;
        check("b2b_valid", io.out_valid, 1);
        check("b2b_tag", io.out_tag, b_t[k-3]);
        if (k == 3) check("b2b_y1", io.out_y, 32'h3F800000);
        if (k == 4) check("b2b_y4", io.out_y, 32'h40000000);
        if (k == 5) check("b2b_y2_ulp", (io.out_y >= 32'h3FB504F2) && (io.out_y <= 32'h3FB504F4), 1);
      end
      @(negedge clk);
    end
    check("b2b_drained", io.out_valid, 0);

    // stalled consumer: credits allow exactly DEPTH acceptances
    io.out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      io.in_valid = 1'b1; io.in_x = sq_x[acc]; io.in_tag = 5'(10 + acc);
      rdy = io.in_ready;
      check("fill_in_ready", rdy, (k < 4));
      @(negedge clk);
      if (rdy) acc++;
    end
    io.in_valid = 1'b0;
    check("fill_accepted", acc, 4);
    check("fill_busy", io.busy, 1);
    io.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", io.out_valid, 1);
      check("drain_y", io.out_y, sq_y[k]);
      check("drain_tag", io.out_tag, 5'(10 + k));
      check("drain_in_ready", io.in_ready, (k != 0));
      @(negedge clk);
    end
    check("drain_empty", io.out_valid, 0);

`ifdef FSQRT_SPECIAL_EN
    run_one(32'hC0800000, 5'd5, 32'h7FC00000, 1'b1, "sp_neg");
    run_one(32'h7F800000, 5'd6, 32'h7F800000, 1'b0, "sp_pinf");
    run_one(32'h80000000, 5'd7, 32'h80000000, 1'b0, "sp_nzero");
    run_one(32'h7F800001, 5'd8, 32'h7FC00001, 1'b1, "sp_snan");
    run_one(32'hFF800000, 5'd9, 32'h7FC00000, 1'b1, "sp_ninf");
`endif

    // reset with two in flight and two buffered
    @(negedge clk);
    io.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      io.in_valid = 1'b1; io.in_x = sq_x[k]; io.in_tag = 5'(20 + k);
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    check("prerst_valid", io.out_valid, 1);
    check("prerst_busy", io.busy, 1);
    rstn = 1'b0;
    #1;
    check_idle("midrst");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    io.out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (io.out_valid) seen++;
    end
    check("postrst_stale", seen, 0);
    check("postrst_busy", io.busy, 0);

    // randomized valid/ready against an in-order reference queue
    pushed = 0; popped = 0; cyc = 0;
    while (pushed < 10000 && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      idx = $urandom_range(0, 4);
      io.in_valid  = ($urandom_range(0, 3) != 0);
      io.in_x      = sq_x[idx];
      io.in_tag    = pushed[4:0];
      io.out_ready = ($urandom_range(0, 3) != 0);
      if (io.out_valid && io.out_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious", 1, 0);
        end else begin
          exp_e = q.pop_front();
          check("rand_head", {io.out_y, io.out_tag}, exp_e);
          popped++;
        end
      end
      if (io.in_valid && io.in_ready) begin
        q.push_back({sq_y[idx], pushed[4:0]});
        pushed++;
      end
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (io.out_valid) begin
        if (q.size() == 0) begin
          check("rand_spurious", 1, 0);
        end else begin
          exp_e = q.pop_front();
          check("rand_head", {io.out_y, io.out_tag}, exp_e);
          popped++;
        end
      end
      @(negedge clk);
    end
    check("rand_pushed", pushed, 10000);
    check("rand_popped", popped, 10000);
    check("rand_q_empty", q.size(), 0);
    check("rand_busy", io.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/fsqrt_issue.md
# fsqrt_issue

Handshaked issue/collect wrapper around the 2-stage `fsqrt` pipeline, sitting between the FPU dispatch and the writeback arbiter. It accepts tagged square-root requests with valid/ready and drives `fsqrt.x`. It tracks the non-stallable 2-cycle pipeline with a valid/tag shadow and buffers results in a small output FIFO. Credit-based issue control means a stalled consumer never loses a result.

## Interface
- `TAG_W`, default 5: width of the request tag (register index or ROB id).
- `DEPTH`, default 4: output FIFO entries; power of two, ≥2.

Ports:
- `clk`, in, 1: clock; all state on the rising edge.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: request present.
- `in_ready`, out, 1: request accepted when `in_valid & in_ready` at the edge.
- `in_x`, in, 32: IEEE-754 single operand.
- `in_tag`, in, TAG_W: request tag.
- `out_valid`, out, 1: FIFO head valid.
- `out_ready`, in, 1: consumer takes the head when `out_valid & out_ready`.
- `out_y`, out, 32: result.
- `out_tag`, out, TAG_W: tag of the result.
- `out_nv`, out, 1: invalid-operation flag of the result.
- `busy`, out, 1: any request in flight or buffered.

## Operation
- One `fsqrt` instance; `fsqrt.x = in_x` combinationally. Its output is meaningful only when the shadow stage-2 valid is set.
- Shadow pipeline registers:
  - stage 1 `{v1, tag1, spc1}`, loaded from the handshake;
  - stage 2 `{v2, tag2, spc2}`, loaded from stage 1.
  - `spc` holds the special-case override (see Configuration).
- FIFO write when `v2`: data `{y_final, tag2, nv2}`. `y_final` is the `fsqrt.y` or the override.
- FIFO read on `out_valid & out_ready`. `out_y/out_tag/out_nv` come from the head entry, held stable while `out_valid & ~out_ready`.
- Credit rule: `in_ready = (count + v1 + v2) < DEPTH`.
  - Computed from registered state only; there is no combinational path from `out_ready` to `in_ready`.
  - A pop in the same cycle frees its slot only from the next cycle.
  - Guarantees a FIFO write never meets a full FIFO. An overflow is a design error and is asserted in simulation.
- Simultaneous write and read when the FIFO is empty: the write lands, the read does not occur (`out_valid` was 0). When non-empty, both occur and `count` is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` is log2(DEPTH)+1 bits.
- `busy = v1 | v2 | (count != 0)`.
- Ordering is strictly FIFO; results leave in acceptance order.

## Timing
- Request accepted at the edge ending cycle t → `fsqrt` stage 1 at edge t, `y` valid in cycle t+2, FIFO write at edge t+2, `out_valid` in cycle t+3.
- Minimum latency is 3 cycles. Throughput is 1/cycle sustained with `out_ready=1` when DEPTH ≥ 4. Steady occupancy is 3, so `in_ready` stays high.
- Reset values: `in_ready=1`, `out_valid=0`, `out_y=0`, `out_tag=0`, `out_nv=0`, `busy=0`.
  - `v1=v2=0`, pointers and `count` are 0.
- Reset mid-operation clears all in-flight and buffered requests with no output. Stale `fsqrt` contents are ignored because `v2=0`.
- `fsqrt` has no reset. The design must not depend on its power-up state.

## Configuration
- `FSQRT_SPECIAL_EN` defined: classify `in_x` at issue, carry the override in `spc`, and apply it at FIFO write.
  - NaN: result is `in_x | 32'h00400000`; `nv=1` if the NaN is signalling.
  - −inf or negative nonzero normal: result `32'h7FC00000`, `nv=1`.
  - +inf: result `32'h7F800000`.
  - exponent 0 (zero/denormal): result `{sign, 31'b0}`.
  - all others: `fsqrt.y`, `nv=0`.
- `FSQRT_SPECIAL_EN` undefined: `spc` regs are not generated. Result is always `fsqrt.y` and `out_nv` is tied 0.

## Test plan
- Single request `in_x=32'h40800000` (4.0), tag 3, `out_ready=1` → cycle t+3: `out_valid=1`, `out_y=32'h40000000`, `out_tag=3`, `out_nv=0`.
- Back-to-back 1.0, 4.0, 2.0, `out_ready=1` → `32'h3F800000`, `32'h40000000`, `32'h3FB504F3` (±1 ulp) on 3 consecutive cycles; `in_ready` never drops.
- `out_ready=0`, stream requests → exactly DEPTH accepted, then `in_ready=0`. Raise `out_ready` → all DEPTH results in order; `in_ready` returns one cycle after the first pop.
- With `FSQRT_SPECIAL_EN`: `32'hC0800000` → `32'h7FC00000`, nv=1; `32'h7F800000` → `32'h7F800000`; `32'h80000000` → `32'h80000000`; `32'h7F800001` → `32'h7FC00001`, nv=1.
- Assert `rstn=0` with 2 in flight and 2 buffered → outputs at reset values immediately; after release `busy=0` and no stale result ever appears.
- Random valid/ready for 10k requests against a reference model → in-order tags, no loss or duplication, no overflow assertion.
